// File: rtl/rr_decoder_arbiter.sv
// Four-requester round-robin arbiter: registers a 2-bit winner index and drives
// a one-hot grant decoded from it, with bounded hold time and forced release.
module rr_decoder_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);

  state_t     state;
  state_t     next_state;
  logic [1:0] ptr;
  logic [7:0] hold_cnt;
  logic [1:0] win_id;
  logic       win_valid;
  logic       owner_req;
  logic       hold_hit;
  logic       release_now;

  // Scan from the farthest offset down so the candidate nearest ptr wins.
  always_comb begin
    logic [1:0] cand;
    win_valid = 1'b0;
    win_id    = ptr;
    cand      = ptr;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (req[cand]) begin
        win_valid = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign owner_req   = req[gnt_id];
  assign hold_hit    = (hold_cnt == HOLD_LAST);
  assign release_now = done || !owner_req || hold_hit;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (win_valid)   next_state = GRANT;
      GRANT:   if (release_now) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Timeout only flags a release caused purely by the hold limit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr      <= 2'd0;
      hold_cnt <= 8'd0;
      gnt_id   <= 2'd0;
      timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (win_valid) begin
            gnt_id   <= win_id;
            hold_cnt <= 8'd0;
          end
        end
        GRANT: begin
          if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
          if (release_now) begin
            ptr     <= gnt_id + 2'd1;
            timeout <= hold_hit && !done && owner_req;
          end else begin
            timeout <= 1'b0;
          end
        end
        default: timeout <= 1'b0;
      endcase
    end
  end

  always_comb begin
    busy = (state == GRANT);
    gnt  = 4'b0000;
    if (state == GRANT) begin
      case (gnt_id)
        2'd0:    gnt = 4'b0001;
        2'd1:    gnt = 4'b0010;
        2'd2:    gnt = 4'b0100;
        default: gnt = 4'b1000;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Bench for rr_decoder_arbiter (MAX_HOLD = 4): vector table fed through an
// expected-value queue, plus a hand-written asynchronous mid-grant reset.
module tb_rr_decoder_arbiter;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic       rst;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       to;
  } vec_t;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       to;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  rr_decoder_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk),
    .resetn(resetn),
    .req(req),
    .done(done),
    .gnt(gnt),
    .gnt_id(gnt_id),
    .busy(busy),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic addVec(input logic [3:0] r, input logic d, input logic rs,
                        input logic [3:0] g, input logic [1:0] id,
                        input logic b, input logic t);
    vec_t v;
    v.req = r; v.done = d; v.rst = rs;
    v.gnt = g; v.id = id; v.busy = b; v.to = t;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    req  = v.req;
    done = v.done;
    if (v.rst) resetn = 1'b0;
    e.gnt = v.gnt; e.id = v.id; e.busy = v.busy; e.to = v.to;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name);
    exp_t e;
    exp_t a;
    a = {gnt, gnt_id, busy, timeout};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: scoreboard empty, got gnt=%b id=%0d busy=%b timeout=%b",
               name, gnt, gnt_id, busy, timeout);
    end else begin
      e = sb.pop_front();
      if (a !== e) begin
        errors++;
        $display("[TB] FAIL %s: got gnt=%b id=%0d busy=%b timeout=%b, expected gnt=%b id=%0d busy=%b timeout=%b",
                 name, gnt, gnt_id, busy, timeout, e.gnt, e.id, e.busy, e.to);
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t hv;
    resetn = 1'b0;
    req    = 4'b0000;
    done   = 1'b0;

    // Reset, idle, first grant
    addVec(4'b0000, 0, 1, 4'b0000, 2'd0, 0, 0);
    addVec(4'b0000, 0, 0, 4'b0000, 2'd0, 0, 0);
    addVec(4'b0000, 0, 0, 4'b0000, 2'd0, 0, 0);
    addVec(4'b0100, 0, 0, 4'b0100, 2'd2, 1, 0);
    addVec(4'b0000, 0, 0, 4'b0000, 2'd2, 0, 0);
    // Round robin from a fresh reset, done on the second grant cycle
    addVec(4'b0000, 0, 1, 4'b0000, 2'd0, 0, 0);
    addVec(4'b1111, 0, 0, 4'b0001, 2'd0, 1, 0);
    addVec(4'b1111, 0, 0, 4'b0001, 2'd0, 1, 0);
    addVec(4'b1111, 1, 0, 4'b0000, 2'd0, 0, 0);
    addVec(4'b1111, 0, 0, 4'b0010, 2'd1, 1, 0);
    addVec(4'b1111, 0, 0, 4'b0010, 2'd1, 1, 0);
    addVec(4'b1111, 1, 0, 4'b0000, 2'd1, 0, 0);
    addVec(4'b1111, 0, 0, 4'b0100, 2'd2, 1, 0);
    addVec(4'b1111, 0, 0, 4'b0100, 2'd2, 1, 0);
    addVec(4'b1111, 1, 0, 4'b0000, 2'd2, 0, 0);
    addVec(4'b1111, 0, 0, 4'b1000, 2'd3, 1, 0);
    addVec(4'b1111, 0, 0, 4'b1000, 2'd3, 1, 0);
    addVec(4'b1111, 1, 0, 4'b0000, 2'd3, 0, 0);
    addVec(4'b1111, 0, 0, 4'b0001, 2'd0, 1, 0);
    addVec(4'b1111, 1, 0, 4'b0000, 2'd0, 0, 0);
    // Priority wrap with req = 1001
    addVec(4'b1001, 0, 0, 4'b1000, 2'd3, 1, 0);
    addVec(4'b1001, 1, 0, 4'b0000, 2'd3, 0, 0);
    addVec(4'b1001, 0, 0, 4'b0001, 2'd0, 1, 0);
    addVec(4'b1001, 1, 0, 4'b0000, 2'd0, 0, 0);
    addVec(4'b1001, 0, 0, 4'b1000, 2'd3, 1, 0);
    addVec(4'b1001, 1, 0, 4'b0000, 2'd3, 0, 0);
    // Hold limit: four grant cycles, one timeout dead cycle, then re-grant
    addVec(4'b0010, 0, 0, 4'b0010, 2'd1, 1, 0);
    addVec(4'b0010, 0, 0, 4'b0010, 2'd1, 1, 0);
    addVec(4'b0010, 0, 0, 4'b0010, 2'd1, 1, 0);
    addVec(4'b0010, 0, 0, 4'b0010, 2'd1, 1, 0);
    addVec(4'b0010, 0, 0, 4'b0000, 2'd1, 0, 1);
    addVec(4'b0010, 0, 0, 4'b0010, 2'd1, 1, 0);
    // done coinciding with the hold limit is a normal release
    addVec(4'b0010, 0, 0, 4'b0010, 2'd1, 1, 0);
    addVec(4'b0010, 0, 0, 4'b0010, 2'd1, 1, 0);
    addVec(4'b0010, 0, 0, 4'b0010, 2'd1, 1, 0);
    addVec(4'b0010, 1, 0, 4'b0000, 2'd1, 0, 0);
    // Owner drops its request mid-grant
    addVec(4'b0110, 0, 0, 4'b0100, 2'd2, 1, 0);
    addVec(4'b0110, 0, 0, 4'b0100, 2'd2, 1, 0);
    addVec(4'b0010, 0, 0, 4'b0000, 2'd2, 0, 0);
    addVec(4'b0010, 0, 0, 4'b0010, 2'd1, 1, 0);
    addVec(4'b0000, 0, 0, 4'b0000, 2'd1, 0, 0);
    // Other requests arriving mid-grant leave the owner alone
    addVec(4'b1000, 0, 0, 4'b1000, 2'd3, 1, 0);
    addVec(4'b1111, 0, 0, 4'b1000, 2'd3, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i));
      if (vecs[i].rst) resetn = 1'b1;
    end

    // Asynchronous reset while requester 3 owns the slot
    #2;
    resetn = 1'b0;
    #1;
    sb.push_back(exp_t'{4'b0000, 2'd0, 1'b0, 1'b0});
    checkOutput("async_reset_mid_grant");
    resetn = 1'b1;
    @(posedge clk);
    #1;
    hv.req = 4'b1001; hv.done = 1'b0; hv.rst = 1'b0;
    hv.gnt = 4'b0001; hv.id = 2'd0; hv.busy = 1'b1; hv.to = 1'b0;
    applyStimulus(hv);
    checkOutput("post_reset_ptr0");
    hv.done = 1'b1; hv.gnt = 4'b0000; hv.busy = 1'b0;
    applyStimulus(hv);
    checkOutput("post_reset_release");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
